sm_sorter: RTL

//  Batch sorter for N-bit sign-magnitude words (MSB = sign, 1 = minus; low N-1 bits = modulus).

---
 rtl/sm_pkg.sv | 13 +
 rtl/sm_sorter_cmp.sv | 23 ++
 rtl/sm_sorter.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/sm_pkg.sv
// Shared definitions for the sign-magnitude batch sorter: sign encodings and FSM states.
package sm_pkg;

  localparam logic SIGN_PLUS  = 1'b0;
  localparam logic SIGN_MINUS = 1'b1;

  typedef enum logic [1:0] {
    LOAD,
    SORT,
    DRAIN
  } sort_state_e;

endpackage

// File: rtl/sm_sorter_cmp.sv
// Sign-magnitude "a >= b" compare: plus beats minus, and -0 ranks below +0.
module sm_sorter_cmp
  import sm_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  output logic         ge_o
);

  always_comb begin
    if (a_i[N-1] != b_i[N-1]) begin
      ge_o = (a_i[N-1] == SIGN_PLUS);
    end else if (a_i[N-1] == SIGN_PLUS) begin
      ge_o = (a_i[N-2:0] >= b_i[N-2:0]);
    end else begin
      // Both minus: the smaller modulus is the larger value.
      ge_o = (a_i[N-2:0] <= b_i[N-2:0]);
    end
  end

endmodule

// File: rtl/sm_sorter.sv
// Batch sorter: loads up to DEPTH sign-magnitude words, odd-even transposition sorts them
// (largest first) and drains them. Define SM_NEGZERO_FOLD_EN to store an accepted -0 as +0.
module sm_sorter
  import sm_pkg::*;
#(
  parameter int unsigned N     = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_in_valid,
  output logic         o_in_ready,
  input  logic [N-1:0] i_in_data,
  input  logic         i_in_last,
  output logic         o_out_valid,
  input  logic         i_out_ready,
  output logic [N-1:0] o_out_data,
  output logic         o_out_last,
  output logic         o_busy
);

  localparam int unsigned KW    = $clog2(DEPTH + 1);
  localparam int unsigned IW    = $clog2(DEPTH);
  localparam int unsigned NPAIR = DEPTH / 2;

  sort_state_e      state_q, state_d;
  logic [N-1:0]     slot_q [DEPTH];
  logic [N-1:0]     slot_d [DEPTH];
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [KW-1:0]    k_q, k_d;
  logic [IW-1:0]    pass_q, pass_d;
  logic [IW-1:0]    rd_q, rd_d;

  logic [N-1:0]     cmp_a [NPAIR];
  logic [N-1:0]     cmp_b [NPAIR];
  logic [NPAIR-1:0] cmp_ge;
  logic [NPAIR-1:0] sw;
  logic [N-1:0]     nxt_slot [DEPTH];
  logic [DEPTH-1:0] nxt_vld;
  logic [N-1:0]     store_word;
  logic             in_fire, out_fire;

`ifdef SM_NEGZERO_FOLD_EN
  assign store_word = (i_in_data[N-1] == SIGN_MINUS && i_in_data[N-2:0] == '0) ? '0 : i_in_data;
`else
  assign store_word = i_in_data;
`endif

  // Pair gi compares (2gi,2gi+1) on even passes and (2gi+1,2gi+2) on odd passes.
  for (genvar gi = 0; gi < NPAIR; gi++) begin : g_pair
    logic lo_v, hi_v;
    if (2 * gi + 2 < DEPTH) begin : g_mid
      assign cmp_a[gi] = pass_q[0] ? slot_q[2*gi+1] : slot_q[2*gi];
      assign cmp_b[gi] = pass_q[0] ? slot_q[2*gi+2] : slot_q[2*gi+1];
      assign lo_v      = pass_q[0] ? vld_q[2*gi+1]  : vld_q[2*gi];
      assign hi_v      = pass_q[0] ? vld_q[2*gi+2]  : vld_q[2*gi+1];
    end else begin : g_end
      assign cmp_a[gi] = slot_q[2*gi];
      assign cmp_b[gi] = slot_q[2*gi+1];
      assign lo_v      = vld_q[2*gi];
      assign hi_v      = vld_q[2*gi+1] & ~pass_q[0];
    end
    sm_sorter_cmp #(.N(N)) u_cmp (
      .a_i (cmp_a[gi]),
      .b_i (cmp_b[gi]),
      .ge_o(cmp_ge[gi])
    );
    assign sw[gi] = hi_v & (~lo_v | ~cmp_ge[gi]);
  end

  for (genvar j = 0; j < DEPTH; j++) begin : g_slot
    if (j % 2 == 0) begin : g_ev
      if (j > 0) begin : g_o
        assign nxt_slot[j] = pass_q[0] ? (sw[j/2-1] ? slot_q[j-1] : slot_q[j])
                                       : (sw[j/2]   ? slot_q[j+1] : slot_q[j]);
        assign nxt_vld[j]  = pass_q[0] ? (sw[j/2-1] ? vld_q[j-1]  : vld_q[j])
                                       : (sw[j/2]   ? vld_q[j+1]  : vld_q[j]);
      end else begin : g_n
        assign nxt_slot[j] = (!pass_q[0] && sw[0]) ? slot_q[1] : slot_q[0];
        assign nxt_vld[j]  = (!pass_q[0] && sw[0]) ? vld_q[1]  : vld_q[0];
      end
    end else begin : g_od
      if (j < DEPTH - 1) begin : g_o
        assign nxt_slot[j] = pass_q[0] ? (sw[j/2] ? slot_q[j+1] : slot_q[j])
                                       : (sw[j/2] ? slot_q[j-1] : slot_q[j]);
        assign nxt_vld[j]  = pass_q[0] ? (sw[j/2] ? vld_q[j+1]  : vld_q[j])
                                       : (sw[j/2] ? vld_q[j-1]  : vld_q[j]);
      end else begin : g_n
        assign nxt_slot[j] = (!pass_q[0] && sw[j/2]) ? slot_q[j-1] : slot_q[j];
        assign nxt_vld[j]  = (!pass_q[0] && sw[j/2]) ? vld_q[j-1]  : vld_q[j];
      end
    end
  end

  always_comb begin
    o_in_ready  = (state_q == LOAD) && !i_rst;
    o_out_valid = (state_q == DRAIN);
    o_out_data  = (state_q == DRAIN) ? slot_q[rd_q] : '0;
    o_out_last  = (state_q == DRAIN) && (KW'(rd_q) == k_q - KW'(1));
    o_busy      = (state_q != LOAD);
  end

  assign in_fire  = i_in_valid & o_in_ready;
  assign out_fire = o_out_valid & i_out_ready;

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    vld_d   = vld_q;
    k_d     = k_q;
    pass_d  = pass_q;
    rd_d    = rd_q;
    unique case (state_q)
      LOAD: begin
        if (in_fire) begin
          slot_d[k_q[IW-1:0]] = store_word;
          vld_d[k_q[IW-1:0]]  = 1'b1;
          k_d                 = k_q + KW'(1);
          if (i_in_last || k_q == KW'(DEPTH - 1)) begin
            state_d = SORT;
            pass_d  = '0;
          end
        end
      end
      SORT: begin
        slot_d = nxt_slot;
        vld_d  = nxt_vld;
        pass_d = pass_q + IW'(1);
        if (pass_q == IW'(DEPTH - 1)) begin
          state_d = DRAIN;
          rd_d    = '0;
        end
      end
      DRAIN: begin
        if (out_fire) begin
          if (o_out_last) begin
            state_d = LOAD;
            k_d     = '0;
            vld_d   = '0;
            rd_d    = '0;
          end else begin
            rd_d = rd_q + IW'(1);
          end
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= LOAD;
      vld_q   <= '0;
      k_q     <= '0;
      pass_q  <= '0;
      rd_q    <= '0;
      for (int i = 0; i < DEPTH; i++) slot_q[i] <= '0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      vld_q   <= vld_d;
      k_q     <= k_d;
      pass_q  <= pass_d;
      rd_q    <= rd_d;
    end
  end

endmodule
